// File: rtl/uart_pkg.sv
// Shared UART definitions: baud codes, divisor lookup and transmitter FSM states.
package uart_pkg;

   localparam int unsigned DIV_W = 13;

   localparam logic [2:0] BAUD_115200 = 3'd0;
   localparam logic [2:0] BAUD_57600  = 3'd1;
   localparam logic [2:0] BAUD_38400  = 3'd2;
   localparam logic [2:0] BAUD_19200  = 3'd3;
   localparam logic [2:0] BAUD_9600   = 3'd4;
   localparam logic [2:0] BAUD_230400 = 3'd5;
   localparam logic [2:0] BAUD_460800 = 3'd6;

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;

   // Code 7 is reserved and falls back to 115200.
   function automatic logic [DIV_W-1:0] baud_div(input logic [2:0] code,
                                                 input int unsigned clk_freq);
      int unsigned baud;
      case (code)
         BAUD_57600:  baud = 57600;
         BAUD_38400:  baud = 38400;
         BAUD_19200:  baud = 19200;
         BAUD_9600:   baud = 9600;
         BAUD_230400: baud = 230400;
         BAUD_460800: baud = 460800;
         default:     baud = 115200;
      endcase
      return DIV_W'(clk_freq / baud);
   endfunction

endpackage

// File: rtl/uart_baud_div.sv
// Loadable bit-period counter; bit_end marks the last cycle of each period.
module uart_baud_div
   import uart_pkg::*;
(
   input  logic             sysclk,
   input  logic             rst,
   input  logic             load,
   input  logic [DIV_W-1:0] div,
   output logic             bit_end
);

   logic [DIV_W-1:0] cnt;
   logic [DIV_W-1:0] period;

   assign bit_end = (cnt == period - DIV_W'(1));

   always_ff @(posedge sysclk or posedge rst) begin
      if (rst) begin
         cnt    <= '0;
         period <= '0;
      end else if (load) begin
         cnt    <= '0;
         period <= div;
      end else if (bit_end) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + DIV_W'(1);
      end
   end

endmodule

// File: rtl/uart_transmit.sv
// 8N1 UART transmitter: one frame per accepted send_en, bit period from Baud_set.
module uart_transmit
   import uart_pkg::*;
#(
   parameter int unsigned CLK_FREQ = 50_000_000,
   parameter int unsigned DATA_W   = 8
) (
   input  logic              sysclk,
   input  logic              rst,
   input  logic [2:0]        Baud_set,
   input  logic [DATA_W-1:0] Data,
   input  logic              send_en,
   output logic              uart_tx,
   output logic              tx_busy,
   output logic              tx_done
);

   localparam int unsigned         IDX_W    = $clog2(DATA_W);
   localparam logic [IDX_W-1:0]    LAST_IDX = IDX_W'(DATA_W - 1);

   tx_state_t         state;
   logic [DATA_W-1:0] shreg;
   logic [IDX_W-1:0]  idx;
   logic [IDX_W-1:0]  idx_nxt;
   logic [DIV_W-1:0]  div_r;
   logic [DIV_W-1:0]  div_load;
   logic              load;
   logic              bit_end;

   // The stop bit is timed with DIV-1 so tx_done lands in its final cycle while
   // the line stays high until the next accept edge, keeping it DIV cycles long.
   always_comb begin
      load     = 1'b0;
      div_load = baud_div(Baud_set, CLK_FREQ);
      idx_nxt  = idx + IDX_W'(1);
      case (state)
         IDLE: load = send_en;
         DATA: begin
            if (bit_end && idx == LAST_IDX) begin
               load     = 1'b1;
               div_load = div_r - DIV_W'(1);
            end
         end
         default: ;
      endcase
   end

   uart_baud_div u_baud_div (
      .sysclk  (sysclk),
      .rst     (rst),
      .load    (load),
      .div     (div_load),
      .bit_end (bit_end)
   );

   always_ff @(posedge sysclk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         shreg   <= '0;
         idx     <= '0;
         div_r   <= '0;
         uart_tx <= 1'b1;
         tx_busy <= 1'b0;
         tx_done <= 1'b0;
      end else begin
         tx_done <= 1'b0;
         case (state)
            IDLE: begin
               if (send_en) begin
                  shreg   <= Data;
                  div_r   <= div_load;
                  uart_tx <= 1'b0;
                  tx_busy <= 1'b1;
                  state   <= START;
               end
            end
            START: begin
               if (bit_end) begin
                  idx     <= '0;
                  uart_tx <= shreg[0];
                  state   <= DATA;
               end
            end
            DATA: begin
               if (bit_end) begin
                  if (idx == LAST_IDX) begin
                     uart_tx <= 1'b1;
                     state   <= STOP;
                  end else begin
                     idx     <= idx_nxt;
                     uart_tx <= shreg[idx_nxt];
                  end
               end
            end
            STOP: begin
               if (bit_end) begin
                  tx_done <= 1'b1;
                  tx_busy <= 1'b0;
                  state   <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
